// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- multi-cycle sequencing FSM for the 32-bit, 8-register core.
//
// Steps each instruction through FETCH, DECODE, EXEC (multiply only), MEM and
// WB, and owns every datapath write enable. All outputs are combinational
// from the current state and inputs.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   start                 leave IDLE and begin fetching (sampled in IDLE only)
//   imem_req/imem_ready   instruction fetch handshake; ir_we captures IR
//   RegWrite..Halt, ALUop decoder controls driven from IR (ALUop 1 = MUL)
//   eq                    R[rs1]==R[rs2], valid in DECODE
//   mul_start/mul_done    iterative multiplier handshake
//   dmem_req/dmem_we/dmem_ready  data memory handshake (dmem_we 1 = store)
//   rf_we, pc_we, pc_sel  register file / PC strobes; pc_sel 0:+1 1:+off22 2:+off28
//   busy, halted          status
//
// Optional feature: define MULTICYCLE_CTRL_PERF_EN to add the 32-bit
// performance counters cycle_cnt (busy cycles) and instr_cnt (retired
// instructions, including HALT).

module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       imem_req,
    input  logic       imem_ready,
    output logic       ir_we,
    input  logic       RegWrite,
    input  logic       MemRead,
    input  logic       MemWrite,
    input  logic       Branch,
    input  logic       Jump,
    input  logic       Halt,
    input  logic [3:0] ALUop,
    input  logic       eq,
    output logic       mul_start,
    input  logic       mul_done,
    output logic       dmem_req,
    output logic       dmem_we,
    input  logic       dmem_ready,
    output logic       rf_we,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic       busy,
    output logic       halted
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALTED = 3'd6;

    localparam logic [3:0] ALU_MUL  = 4'd1;

    localparam logic [1:0] PC_INC   = 2'd0;
    localparam logic [1:0] PC_BR    = 2'd1;
    localparam logic [1:0] PC_JMP   = 2'd2;

    logic [2:0] state;
    logic [2:0] state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        mul_start = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        rf_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = PC_INC;
        halted    = 1'b0;
        busy      = (state != S_IDLE) && (state != S_HALTED);

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we     = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                // Decoder controls are resolved strictly in priority order.
                if (Halt) begin
                    state_nxt = S_HALTED;
                end else if (Jump) begin
                    pc_we     = 1'b1;
                    pc_sel    = PC_JMP;
                    state_nxt = S_FETCH;
                end else if (Branch) begin
                    pc_we     = 1'b1;
                    pc_sel    = eq ? PC_BR : PC_INC;
                    state_nxt = S_FETCH;
                end else if (MemRead || MemWrite) begin
                    state_nxt = S_MEM;
                end else if (RegWrite && (ALUop == ALU_MUL)) begin
                    mul_start = 1'b1;
                    state_nxt = S_EXEC;
                end else if (RegWrite) begin
                    state_nxt = S_WB;
                end else begin
                    pc_we     = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_EXEC: begin
                // mul_done is only looked at here, so a done coincident with
                // the start pulse in DECODE never ends the wait early.
                if (mul_done) begin
                    state_nxt = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = MemWrite;
                if (dmem_ready) begin
                    if (MemWrite) begin
                        pc_we     = 1'b1;
                        state_nxt = S_FETCH;
                    end else begin
                        state_nxt = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we     = 1'b1;
                pc_we     = 1'b1;
                state_nxt = S_FETCH;
            end
            S_HALTED: begin
                halted = 1'b1;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    // HALT never raises pc_we, so its retirement is counted on the
    // DECODE->HALTED transition instead.
    logic halt_retire;
    assign halt_retire = (state == S_DECODE) && (state_nxt == S_HALTED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if (busy) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            if (pc_we || halt_retire) begin
                instr_cnt <= instr_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl. A program of instructions with randomized
// decoder side-bits and memory/multiplier latencies is planned up front; the
// expected per-cycle output trace is derived from the instruction classes and
// pushed into a queue, a reactive driver plays memory/multiplier/decoder, and
// a monitor pops and compares one trace entry per cycle.

module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       imem_req;
    logic       imem_ready;
    logic       ir_we;
    logic       RegWrite, MemRead, MemWrite, Branch, Jump, Halt;
    logic [3:0] ALUop;
    logic       eq;
    logic       mul_start;
    logic       mul_done;
    logic       dmem_req;
    logic       dmem_we;
    logic       dmem_ready;
    logic       rf_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       busy;
    logic       halted;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instr_cnt;
`endif

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .imem_req   (imem_req),
        .imem_ready (imem_ready),
        .ir_we      (ir_we),
        .RegWrite   (RegWrite),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Branch     (Branch),
        .Jump       (Jump),
        .Halt       (Halt),
        .ALUop      (ALUop),
        .eq         (eq),
        .mul_start  (mul_start),
        .mul_done   (mul_done),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ready (dmem_ready),
        .rf_we      (rf_we),
        .pc_we      (pc_we),
        .pc_sel     (pc_sel),
        .busy       (busy),
        .halted     (halted)
`ifdef MULTICYCLE_CTRL_PERF_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt)
`endif
    );

    typedef enum int {K_ADD, K_LI, K_MUL, K_LOAD, K_STORE, K_BEQ, K_JMP, K_NOP, K_HALT} kind_t;

    typedef struct {
        kind_t       kind;
        logic        rw, mr, mwr, br, jp, ht;
        logic [3:0]  aluop;
        logic        eqv;
        int unsigned fwait;
        int unsigned mwait;
        int unsigned mcyc;
    } instr_t;

    typedef struct packed {
        logic       busy;
        logic       halted;
        logic       imem_req;
        logic       ir_we;
        logic       mul_start;
        logic       dmem_req;
        logic       dmem_we;
        logic       rf_we;
        logic       pc_we;
        logic [1:0] pc_sel;
    } vec_t;

    instr_t      plan[$];
    vec_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int unsigned exp_busy  = 0;
    int unsigned exp_instr = 0;
    int unsigned trace_idx = 0;
    bit          mon_en = 1'b0;
    bit          drv_en = 1'b0;

    // ---------------------------------------------------------------- model
    function automatic instr_t mk(input kind_t k, input int unsigned fw,
                                  input int unsigned mw, input int unsigned mc,
                                  input logic e);
        instr_t p;
        p.kind  = k;
        p.fwait = fw;
        p.mwait = mw;
        p.mcyc  = mc;
        p.eqv   = e;
        p.aluop = 4'($urandom_range(0, 15));
        {p.rw, p.mr, p.mwr, p.br, p.jp, p.ht} = '0;
        case (k)
            K_ADD, K_LI: begin p.rw = 1'b1; if (p.aluop == 4'd1) p.aluop = 4'd0; end
            K_MUL:   begin p.rw = 1'b1; p.aluop = 4'd1; end
            K_LOAD:  begin p.mr = 1'b1; p.rw = 1'b1; end
            K_STORE: p.mwr = 1'b1;
            K_BEQ:   begin p.br = 1'b1; p.rw = 1'($urandom_range(0, 1)); p.mr = 1'($urandom_range(0, 1)); end
            K_JMP:   begin p.jp = 1'b1; p.br = 1'($urandom_range(0, 1)); p.rw = 1'($urandom_range(0, 1)); end
            K_HALT:  begin p.ht = 1'b1; {p.jp, p.br, p.mr, p.rw} = 4'($urandom_range(0, 15)); end
            default: ;
        endcase
        return p;
    endfunction

    function automatic vec_t bv(input logic b);
        vec_t v;
        v = '0;
        v.busy = b;
        return v;
    endfunction

    task automatic push_v(input vec_t v);
        exp_q.push_back(v);
        if (v.busy)  exp_busy++;
        if (v.pc_we) exp_instr++;
    endtask

    task automatic expect_instr(input instr_t p);
        vec_t v;
        v = bv(1'b1); v.imem_req = 1'b1;
        for (int unsigned i = 0; i < p.fwait; i++) push_v(v);
        v.ir_we = 1'b1;
        push_v(v);
        case (p.kind)
            K_HALT: begin push_v(bv(1'b1)); exp_instr++; end
            K_JMP:  begin v = bv(1'b1); v.pc_we = 1'b1; v.pc_sel = 2'd2; push_v(v); end
            K_BEQ:  begin v = bv(1'b1); v.pc_we = 1'b1; v.pc_sel = p.eqv ? 2'd1 : 2'd0; push_v(v); end
            K_NOP:  begin v = bv(1'b1); v.pc_we = 1'b1; push_v(v); end
            K_ADD, K_LI: begin
                push_v(bv(1'b1));
                v = bv(1'b1); v.rf_we = 1'b1; v.pc_we = 1'b1; push_v(v);
            end
            K_MUL: begin
                v = bv(1'b1); v.mul_start = 1'b1; push_v(v);
                for (int unsigned i = 0; i < p.mcyc; i++) push_v(bv(1'b1));
                v = bv(1'b1); v.rf_we = 1'b1; v.pc_we = 1'b1; push_v(v);
            end
            K_LOAD: begin
                push_v(bv(1'b1));
                v = bv(1'b1); v.dmem_req = 1'b1;
                for (int unsigned i = 0; i <= p.mwait; i++) push_v(v);
                v = bv(1'b1); v.rf_we = 1'b1; v.pc_we = 1'b1; push_v(v);
            end
            K_STORE: begin
                push_v(bv(1'b1));
                v = bv(1'b1); v.dmem_req = 1'b1; v.dmem_we = 1'b1;
                for (int unsigned i = 0; i < p.mwait; i++) push_v(v);
                v.pc_we = 1'b1; push_v(v);
            end
            default: ;
        endcase
    endtask

    // -------------------------------------------------------------- monitor
    initial begin
        vec_t e, g;
        forever begin
            @(negedge clk);
            if (mon_en && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = '{busy, halted, imem_req, ir_we, mul_start, dmem_req,
                      dmem_we, rf_we, pc_we, pc_sel};
                checks++;
                if (g !== e) begin
                    failures++;
                    $display("FAIL trace[%0d] got=%b required=%b (busy,halted,imem_req,ir_we,mul_start,dmem_req,dmem_we,rf_we,pc_we,pc_sel)",
                             trace_idx, g, e);
                end
                trace_idx++;
            end
        end
    end

    // --------------------------------------------------------------- driver
    // Reacts to requests with the planned latencies; when nothing is
    // requested the ready/done inputs carry random noise.
    initial begin
        int unsigned idx = 0, fcnt = 0, mcnt = 0, ecnt = 0;
        bit load_next = 0, exec_pend = 0, in_exec = 0;
        instr_t cur;
        wait (drv_en == 1'b1);
        forever begin
            @(posedge clk);
            #1;
            if (!drv_en) break;
            start = 1'($urandom_range(0, 1));
            if (load_next) begin
                cur = plan[idx];
                idx++;
                load_next = 0;
                {RegWrite, MemRead, MemWrite, Branch, Jump, Halt} =
                    {cur.rw, cur.mr, cur.mwr, cur.br, cur.jp, cur.ht};
                ALUop = cur.aluop;
                eq    = cur.eqv;
                exec_pend = (cur.kind == K_MUL);
                mul_done  = 1'($urandom_range(0, 1));
            end else if (exec_pend) begin
                exec_pend = 0;
                in_exec   = 1;
                ecnt      = 0;
            end
            if (in_exec) begin
                ecnt++;
                mul_done = (ecnt == cur.mcyc);
                if (mul_done) in_exec = 0;
            end else if (!exec_pend) begin
                mul_done = 1'($urandom_range(0, 1));
            end
            if (imem_req && idx < plan.size()) begin
                imem_ready = (fcnt == plan[idx].fwait);
                if (imem_ready) begin load_next = 1; fcnt = 0; end
                else fcnt++;
            end else begin
                fcnt = 0;
                imem_ready = 1'($urandom_range(0, 1));
            end
            if (dmem_req) begin
                dmem_ready = (mcnt == cur.mwait);
                if (dmem_ready) mcnt = 0;
                else mcnt++;
            end else begin
                mcnt = 0;
                dmem_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // ----------------------------------------------------------------- main
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; mul_done = 1'b0;
        {RegWrite, MemRead, MemWrite, Branch, Jump, Halt} = '0;
        ALUop = '0; eq = 1'b0;

        // Directed head: zero-wait ADD, both BEQ outcomes, JMP, delayed
        // LOAD/STORE, 5-cycle MUL; then a random body ending in HALT.
        plan.push_back(mk(K_ADD,   0, 0, 1, 1'b0));
        plan.push_back(mk(K_BEQ,   0, 0, 1, 1'b1));
        plan.push_back(mk(K_BEQ,   1, 0, 1, 1'b0));
        plan.push_back(mk(K_JMP,   0, 0, 1, 1'b1));
        plan.push_back(mk(K_LOAD,  0, 3, 1, 1'b0));
        plan.push_back(mk(K_STORE, 0, 3, 1, 1'b0));
        plan.push_back(mk(K_MUL,   0, 0, 5, 1'b0));
        plan.push_back(mk(K_NOP,   2, 0, 1, 1'b0));
        for (int i = 0; i < 32; i++)
            plan.push_back(mk(kind_t'($urandom_range(0, 7)), $urandom_range(0, 3),
                              $urandom_range(0, 3), $urandom_range(1, 6),
                              1'($urandom_range(0, 1))));
        plan.push_back(mk(K_HALT, 1, 0, 1, 1'b0));

        for (int i = 0; i < 5; i++) push_v(bv(1'b0));  // reset + IDLE cycles
        foreach (plan[i]) expect_instr(plan[i]);
        for (int i = 0; i < 6; i++) begin
            vec_t h;
            h = '0; h.halted = 1'b1;
            push_v(h);
        end

        mon_en = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start  = 1'b1;
        drv_en = 1'b1;

        for (int c = 0; c < 4000 && exp_q.size() != 0; c++) @(negedge clk);
        #1;
        chk("trace_drained", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;
        drv_en = 1'b0;
`ifdef MULTICYCLE_CTRL_PERF_EN
        chk("cycle_cnt", cycle_cnt, 32'(exp_busy));
        chk("instr_cnt", instr_cnt, 32'(exp_instr));
`endif
        chk("halted_sticky", {31'd0, halted}, 32'd1);

        // Reset mid-FETCH must drop imem_req asynchronously.
        @(posedge clk); #1;
        rst_n = 1'b0; start = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; mul_done = 1'b0;
        #1;
        chk("reset_halted", {31'd0, halted}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        #2;
        chk("fetch_req", {31'd0, imem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midfetch_imem_req", {31'd0, imem_req}, 32'd0);
        chk("midfetch_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", {29'd0, busy, imem_req, ir_we}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencing FSM for the 32-bit, 8-register core. It steps each instruction through fetch, decode, execute, memory and writeback. It consumes the decoder's control outputs and drives the strobes for IR, PC, register file, data memory and the iterative multiplier. It sits between the instruction/data memory handshakes and the datapath, and owns all write enables.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  level; leaves IDLE and begins fetching
- imem_req  out  1  instruction read request
- imem_ready  in  1  instruction valid on imem_rdata this cycle
- ir_we  out  1  capture instruction into IR
- RegWrite, MemRead, MemWrite, Branch, Jump, Halt  in  1 each  decoder control outputs, driven from IR
- ALUop  in  4  decoder ALU select; 1 = MUL
- eq  in  1  R[rs1]==R[rs2], valid in DECODE
- mul_start  out  1  one-cycle multiplier start pulse
- mul_done  in  1  multiplier result valid
- dmem_req  out  1  data memory request
- dmem_we  out  1  1 = store, 0 = load
- dmem_ready  in  1  data access complete this cycle
- rf_we  out  1  register file write strobe
- pc_we  out  1  PC update strobe
- pc_sel  out  2  PC source: 0 = PC+1, 1 = PC+1+off22, 2 = PC+1+off28
- busy  out  1  state not IDLE and not HALTED
- halted  out  1  HALT retired

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED. Outputs are combinational from state and inputs; no output is registered.
- **IDLE**: all strobes 0. start=1 → FETCH.
- **FETCH**: imem_req=1 until imem_ready. On the ready cycle, ir_we=1 → DECODE.
- **DECODE**: decoder outputs are valid from IR. Priority is top to bottom:
  - Halt → HALTED.
  - Jump → pc_we=1, pc_sel=2 → FETCH.
  - Branch → pc_we=1, pc_sel = eq ? 1 : 0 → FETCH.
  - MemRead|MemWrite → MEM.
  - RegWrite & ALUop==1 → mul_start=1 → EXEC.
  - RegWrite (ADD, LI) → WB.
  - Anything else (unused opcode) is a NOP: pc_we=1, pc_sel=0 → FETCH.
- **EXEC**: wait for mul_done, then → WB. mul_done arriving in the same cycle as the start pulse is ignored.
- **MEM**: dmem_req=1 and dmem_we=MemWrite, held until dmem_ready. On ready, a load goes → WB. A store sets pc_we=1, pc_sel=0 → FETCH.
- **WB**: rf_we=1, pc_we=1, pc_sel=0 → FETCH.
- **HALTED**: halted=1 and all strobes 0. The FSM is sticky until rst_n; start is ignored.
- Exactly one of ir_we, pc_we, rf_we, mul_start may be asserted per cycle, except in WB, where rf_we and pc_we assert together.
- A request, once raised, stays high with constant dmem_we until its ready. A ready seen while no request is up is ignored.

## Timing
- Reset (async, immediate): state IDLE. imem_req, ir_we, RegWrite-derived strobes, mul_start, dmem_req, dmem_we, rf_we, pc_we, busy and halted are all 0; pc_sel=0. Performance counters are 0.
- Reset mid-access drops imem_req/dmem_req in the same cycle. After deassertion the FSM restarts from IDLE; no partial writeback occurs.
- With zero-wait memory (ready in the first request cycle), cycles per instruction are:
  - JMP, BEQ, NOP, HALT: 2
  - ADD, LI: 3
  - STORE: 3
  - LOAD: 4
  - MUL: 3 + N, where N is the number of EXEC cycles until mul_done.
- Each memory wait cycle adds one cycle in FETCH or MEM.
- start is sampled only in IDLE.

## Configuration
- `MULTICYCLE_CTRL_PERF_EN` defined: adds outputs cycle_cnt[31:0] and instr_cnt[31:0].
  - cycle_cnt increments on every cycle with busy=1.
  - instr_cnt increments on every pc_we cycle and on the DECODE→HALTED transition.
  - Both counters wrap at 2^32 and clear only on reset.
- Undefined: neither port nor the counter logic exists; all other behaviour is identical.

## Test plan
- Reset with start=0: all outputs 0, busy=0. Pulse start with imem_ready tied to 1 and instruction ADD → ir_we at cycle 1, rf_we+pc_we(pc_sel=0) at cycle 3, back to FETCH.
- BEQ with eq=1 → pc_we=1, pc_sel=1 in DECODE. With eq=0 → pc_sel=0. JMP → pc_sel=2. No rf_we in any of these cases.
- LOAD with dmem_ready delayed 3 cycles → dmem_req held 4 cycles with dmem_we=0, then rf_we in WB. STORE with the same delay → dmem_we=1 held, pc_we on the ready cycle, rf_we never asserts.
- MUL with mul_done after 5 EXEC cycles → single mul_start pulse in DECODE, rf_we exactly once, 8 cycles in total.
- HALT → halted=1 permanently. start and imem_ready toggling cause no strobes. Asserting rst_n low mid-FETCH drops imem_req immediately.
- With `MULTICYCLE_CTRL_PERF_EN` defined, run ADD, LOAD, HALT at zero wait → instr_cnt=3, cycle_cnt=9.
